// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the iterative multiply/divide unit.
//   state_e : FSM encoding (IDLE, MULT, DIV, DONE)
//   OP_MULT / OP_DIV : values of the request opcode bit
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
//   rem_i : current partial remainder (always < div_i)
//   bit_i : next dividend bit shifted into the remainder
//   div_i : divisor magnitude (non-zero when used)
//   rem_o : next partial remainder
//   q_o   : quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < div_i <= 2^(WIDTH-1), so the shifted value needs one extra bit and
  // the top bit of the difference is a clean borrow flag.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_multdiv.sv
// iter_multdiv: iterative signed multiply (radix-2 Booth) / divide (restoring)
// unit with valid/ready handshakes, a pass-through tag and a synchronous flush.
//   clock, reset (async, active-low)
//   in_valid/in_ready/in_op/in_a/in_b/in_tag : request side
//   flush                                    : abort, highest priority
//   out_valid/out_ready/out_result/out_exception/out_tag : result side
//   busy                                     : iteration in progress
module iter_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_exception,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH:0]     acc_q,    acc_d;     // Booth accumulator / division remainder
  logic [WIDTH-1:0]   q_q,      q_d;       // multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   m_q,      m_d;       // multiplicand / divisor magnitude
  logic               qm1_q,    qm1_d;     // Booth Q[-1]
  logic               neg_q,    neg_d;     // quotient must be negated
  logic               ovf_q,    ovf_d;     // most-negative / -1
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q,    exc_d;
  logic [TAG_W-1:0]   tag_q,    tag_d;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     m_ext, booth_sum, acc_shift;
  logic [WIDTH-1:0]   q_shift;
  logic               mult_exc;
  logic [WIDTH-1:0]   rem_next, quo_next, div_res;
  logic               qbit;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Magnitudes; the most-negative value maps onto 2^(WIDTH-1) as unsigned.
  assign a_mag = in_a[WIDTH-1] ? (~in_a + 1'b1) : in_a;
  assign b_mag = in_b[WIDTH-1] ? (~in_b + 1'b1) : in_b;

  // Booth step: the extra accumulator bit keeps acc - m from overflowing when
  // the multiplicand is the most-negative value.
  assign m_ext     = {m_q[WIDTH-1], m_q};
  assign booth_sum = ({q_q[0], qm1_q} == 2'b01) ? acc_q + m_ext :
                     ({q_q[0], qm1_q} == 2'b10) ? acc_q - m_ext : acc_q;
  assign acc_shift = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign q_shift   = {booth_sum[0], q_q[WIDTH-1:1]};
  assign mult_exc  = (acc_shift[WIDTH-1:0] != {WIDTH{q_shift[WIDTH-1]}});

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[WIDTH-1:0]),
    .bit_i (q_q[WIDTH-1]),
    .div_i (m_q),
    .rem_o (rem_next),
    .q_o   (qbit)
  );

  assign quo_next = {q_q[WIDTH-2:0], qbit};
  assign div_res  = neg_q ? (~quo_next + 1'b1) : quo_next;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    tag_d    = tag_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_MULT: begin
          acc_d = acc_shift;
          q_d   = q_shift;
          qm1_d = q_q[0];
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d  = ST_DONE;
            result_d = q_shift;
            exc_d    = mult_exc;
          end
        end
        ST_DIV: begin
          if (m_q == '0) begin
            state_d  = ST_DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            acc_d = {1'b0, rem_next};
            q_d   = quo_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
              state_d  = ST_DONE;
              result_d = div_res;
              exc_d    = ovf_q;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: ;
      endcase

      // A new request overrides the IDLE/DONE decision above, so completion
      // and accept share one edge without a bubble.
      if (accept) begin
        state_d = (in_op == OP_DIV) ? ST_DIV : ST_MULT;
        cnt_d   = '0;
        tag_d   = in_tag;
        acc_d   = '0;
        qm1_d   = 1'b0;
        if (in_op == OP_DIV) begin
          q_d   = a_mag;
          m_d   = b_mag;
          neg_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          ovf_d = (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_b);
        end else begin
          q_d   = in_b;
          m_d   = in_a;
          neg_d = 1'b0;
          ovf_d = 1'b0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset too; the result/tag outputs come
  // straight from them and must read zero during reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      tag_q    <= tag_d;
    end
  end

  assign out_valid     = (state_q == ST_DONE);
  assign busy          = (state_q == ST_MULT) || (state_q == ST_DIV);
  assign out_result    = result_q;
  assign out_exception = exc_q;
  assign out_tag       = tag_q;

endmodule

// File: tb/tb_iter_multdiv.sv
// tb_iter_multdiv: self-checking bench for iter_multdiv (WIDTH=32).
// A queue-based reference model predicts handshake timing and results from
// plain arithmetic; a negedge compare process checks the DUT every cycle.
// Directed cases pin the model with hand-computed literals; a randomized
// phase mixes ops, corner operands, backpressure and flushes.
module tb_iter_multdiv;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_op = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic          out_exception;
  logic [TW-1:0] out_tag;
  logic          busy;

  iter_multdiv #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_exception (out_exception),
    .out_tag       (out_tag),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {exception, result} from plain signed arithmetic.
  function automatic logic [W:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       p;
    logic [63:0]  pv;
    logic [W-1:0] lo;
    int           quo;
    if (op == 1'b0) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      lo = pv[W-1:0];
      return {(pv != {{32{lo[W-1]}}, lo}), lo};
    end
    if (b == '0) return {1'b1, {W{1'b0}}};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, a};
    quo = $signed(a) / $signed(b);
    return {1'b0, quo};
  endfunction

  typedef struct {
    logic [W-1:0]  res;
    logic          exc;
    logic [TW-1:0] tag;
    int            e0;   // accept edge index
    int            due;  // edge after which out_valid is first high
  } exp_t;

  exp_t exp_q[$];

  bit       m_valid, m_busy, m_rdy;
  logic [W:0] m_out;
  exp_t     m_new;

  // Compare process: outputs sampled mid-cycle, model bookkeeping applied for
  // the edge that follows.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", out_result, 0);
      check("rst_exc", out_exception, 0);
      check("rst_tag", out_tag, 0);
    end else begin
      m_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      m_busy  = (exp_q.size() > 0) && (cyc >= exp_q[0].e0) && (cyc < exp_q[0].due);
      m_rdy   = (exp_q.size() == 0) || (m_valid && out_ready);
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_busy);
      check("in_ready", in_ready, m_rdy);
      if (m_valid && out_valid) begin
        check("out_result", out_result, exp_q[0].res);
        check("out_exception", out_exception, exp_q[0].exc);
        check("out_tag", out_tag, exp_q[0].tag);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_valid && out_ready) void'(exp_q.pop_front());
        if (in_valid && m_rdy) begin
          m_out     = model(in_op, in_a, in_b);
          m_new.res = m_out[W-1:0];
          m_new.exc = m_out[W];
          m_new.tag = in_tag;
          m_new.e0  = cyc + 1;
          m_new.due = cyc + 1 + ((in_op && in_b == '0) ? 1 : W);
          exp_q.push_back(m_new);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance; returns accept edge and
  // the number of sampled cycles spent waiting.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output int e0, output int nw);
    bit got = 0;
    e0 = -1;
    nw = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      nw++;
      if (in_ready) begin
        got = 1;
        e0  = cyc + 1;
      end
    end
    check("accept_wait", got, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; counts busy cycles seen on the way.
  task automatic wait_result(output logic [W-1:0] r, output logic e, output logic [TW-1:0] t,
                             output int vc, output int bc);
    bit got = 0;
    r = '0; e = 1'b0; t = '0; vc = -1; bc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (busy) bc++;
      if (out_valid) begin
        got = 1;
        r   = out_result;
        e   = out_exception;
        t   = out_tag;
        vc  = cyc;
      end
    end
    check("result_wait", got, 1);
  endtask

  task automatic run_dir(input string name, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag,
                         input logic [W-1:0] exp_r, input logic exp_e, input int lat);
    int e0, nw, vc, bc;
    logic [W-1:0]  r;
    logic          e;
    logic [TW-1:0] t;
    issue(op, a, b, tag, e0, nw);
    wait_result(r, e, t, vc, bc);
    check({name, "_result"}, r, exp_r);
    check({name, "_exc"}, e, exp_e);
    check({name, "_tag"}, t, tag);
    check({name, "_latency"}, vc - e0, lat);
    check({name, "_busy_cycles"}, bc, lat);
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = 32'h8000_0000;
      3: v = W'($urandom_range(0, 20));
      4: v = -W'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int e0, e1, nw, vc, bc;
    logic [W-1:0]  r, r0;
    logic          e;
    logic [TW-1:0] t;

    // Reset state is checked by the compare process while reset is low.
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    tick();
    reset = 1'b1;
    tick();

    run_dir("t1_mul", 1'b0, 7, -3, 9, 32'hFFFF_FFEB, 1'b0, W);
    run_dir("t2_mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 3, 32'h0000_0000, 1'b1, W);
    run_dir("t2_mul_min", 1'b0, 32'h8000_0000, 1, 4, 32'h8000_0000, 1'b0, W);
    run_dir("t3_div", 1'b1, -7, 2, 5, 32'hFFFF_FFFD, 1'b0, W);
    run_dir("t3_div0", 1'b1, 5, 0, 6, 32'h0000_0000, 1'b1, 1);
    run_dir("t3_div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 7, 32'h8000_0000, 1'b1, W);

    // Backpressure: result held, then new request accepted on the release edge.
    out_ready = 1'b0;
    issue(1'b0, 100, -5, 12, e0, nw);
    wait_result(r0, e, t, vc, bc);
    check("t4_result", r0, 32'hFFFF_FE0C);
    repeat (10) begin
      @(negedge clock);
      check("t4_hold_result", out_result, r0);
      check("t4_hold_tag", out_tag, 12);
      check("t4_hold_in_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    issue(1'b1, 1000, 7, 21, e1, nw);
    check("t4_accept_same_edge", nw, 1);
    wait_result(r, e, t, vc, bc);
    check("t4_next_result", r, 142);
    check("t4_next_tag", t, 21);
    check("t4_next_latency", vc - e1, W);
    tick();

    // Flush on the edge of divide step 10.
    issue(1'b1, 1000, 7, 8, e0, nw);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_busy_after_flush", busy, 0);
    check("t5_valid_after_flush", out_valid, 0);
    check("t5_ready_after_flush", in_ready, 1);
    repeat (40) tick();
    check("t5_no_late_valid", out_valid, 0);
    run_dir("t5_mul", 1'b0, 6, 7, 10, 42, 1'b0, W);

    // Asynchronous reset at step 20 of a multiply.
    issue(1'b0, 12345, -678, 11, e0, nw);
    repeat (19) tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_result", out_result, 0);
    check("t6_exc", out_exception, 0);
    check("t6_tag", out_tag, 0);
    check("t6_in_ready", in_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_dir("t6_mul", 1'b0, 12345, -678, 11, 32'hFF80_490A, 1'b0, W);

    // Randomized phase, checked by the compare process.
    for (int n = 0; n < 60; n++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick(), TW'($urandom), e0, nw);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 20)) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = $urandom;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        wait_result(r, e, t, vc, bc);
        if (!out_ready) begin
          repeat ($urandom_range(1, 4)) tick();
          out_ready = 1'b1;
        end
        tick();
      end
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
